// File: rtl/conv2_pkg.sv
// Shared layer constants and state encoding for the Conv2 row-convolution sequencer.
package conv2_pkg;

    localparam int KERNEL  = 3;
    localparam int OUT_W   = 30;
    localparam int OUT_H   = 42;
    localparam int IN_W    = 32;
    localparam int FADDR_W = 11;
    localparam int POS_W   = 11;

    localparam int TAP_W = 2;
    localparam int COL_W = 5;
    localparam int ROW_W = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_OUTPUT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/conv2_sched_if.sv
// Buffer-read, MAC-array and result-stream signals between the sequencer and its neighbours.
interface conv2_sched_if;
    import conv2_pkg::*;

    logic               feat_rd_en;
    logic [FADDR_W-1:0] feat_rd_addr;
    logic               w_rd_en;
    logic [TAP_W-1:0]   w_rd_addr;
    logic               mac_valid;
    logic               mac_clear;
    logic               mac_done;
    logic               out_valid;
    logic               out_ready;
    logic [POS_W-1:0]   out_pos;

    modport master (
        output feat_rd_en, feat_rd_addr, w_rd_en, w_rd_addr,
        output mac_valid, mac_clear, out_valid, out_pos,
        input  mac_done, out_ready
    );

    modport slave (
        input  feat_rd_en, feat_rd_addr, w_rd_en, w_rd_addr,
        input  mac_valid, mac_clear, out_valid, out_pos,
        output mac_done, out_ready
    );

endinterface

// File: rtl/conv2_pos_cnt.sv
// Output-position counters: column, row, running row base address and linear index.
// The row base grows by IN_W on each column wrap so no multiplier is needed.
module conv2_pos_cnt
    import conv2_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               clr,
    output logic [COL_W-1:0]   col,
    output logic [FADDR_W-1:0] base,
    output logic [POS_W-1:0]   pos,
    output logic               last_pos
);

    logic [ROW_W-1:0] row;
    logic             col_last;

    assign col_last = (col == COL_W'(OUT_W - 1));
    assign last_pos = col_last && (row == ROW_W'(OUT_H - 1));

    // Advance one output position per accepted result; wrap columns into the next row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
            pos  <= '0;
        end else if (clr) begin
            col  <= '0;
            row  <= '0;
            base <= '0;
            pos  <= '0;
        end else if (inc) begin
            pos <= pos + POS_W'(1);
            if (col_last) begin
                col  <= '0;
                row  <= row + ROW_W'(1);
                base <= base + FADDR_W'(IN_W);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv2_sched.sv
// Conv2 sequencer: per output position clears the array, issues KERNEL feature/weight
// reads, waits for the array result and hands it downstream under valid/ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start
//   S_CLEAR  | one-cycle accumulator clear
//   S_ISSUE  | KERNEL cycles of feature/weight reads, tap 0..KERNEL-1
//   S_WAIT   | waiting for the array's mac_done pulse
//   S_OUTPUT | result offered downstream until out_ready
//   S_DONE   | one-cycle done pulse, position counters cleared
module conv2_sched
    import conv2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    conv2_sched_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t             state;
    state_t             state_nx;
    logic [TAP_W-1:0]   tap;
    logic               tap_last;
    logic               issuing;
    logic               pos_inc;
    logic               pos_clr;
    logic               mac_valid_q;
    logic               err_q;
    logic               err_set;
    logic [COL_W-1:0]   col;
    logic [FADDR_W-1:0] base;
    logic [POS_W-1:0]   pos;
    logic               last_pos;

    conv2_pos_cnt u_pos_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pos_inc),
        .clr      (pos_clr),
        .col      (col),
        .base     (base),
        .pos      (pos),
        .last_pos (last_pos)
    );

    assign tap_last = (tap == TAP_W'(KERNEL - 1));
    assign issuing  = (state == S_ISSUE);

    // Once the final tap's mac_valid is out (first WAIT cycle) a result pulse is legal.
    assign err_set = bus.mac_done &&
                     ((state == S_IDLE) || (state == S_CLEAR) ||
                      (state == S_ISSUE) || (state == S_OUTPUT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and position-counter control; abort overrides every transition.
    always_comb begin
        state_nx = state;
        pos_inc  = 1'b0;
        pos_clr  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_CLEAR;
            S_CLEAR:  state_nx = S_ISSUE;
            S_ISSUE:  if (tap_last) state_nx = S_WAIT;
            S_WAIT:   if (bus.mac_done) state_nx = S_OUTPUT;
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    pos_inc  = 1'b1;
                    state_nx = last_pos ? S_DONE : S_CLEAR;
                end
            end
            S_DONE: begin
                pos_clr  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
            pos_inc  = 1'b0;
            pos_clr  = 1'b1;
        end
    end

    // Tap counter runs only inside ISSUE and is zero everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           tap <= '0;
        else if (issuing && !tap_last && !abort) tap <= tap + TAP_W'(1);
        else                                  tap <= '0;
    end

    // mac_valid is the read strobe delayed by the RAMs' one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mac_valid_q <= 1'b0;
        else        mac_valid_q <= issuing && !abort;
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | err_set;
    end

    assign bus.feat_rd_en   = issuing;
    assign bus.w_rd_en      = issuing;
    assign bus.feat_rd_addr = issuing ? (base + FADDR_W'(col) + FADDR_W'(tap)) : '0;
    assign bus.w_rd_addr    = issuing ? tap : '0;
    assign bus.mac_valid    = mac_valid_q;
    assign bus.mac_clear    = (state == S_CLEAR);
    assign bus.out_valid    = (state == S_OUTPUT);
    assign bus.out_pos      = pos;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_conv2_sched.sv
// Directed bench for conv2_sched: full layer pass with backpressure, abort in WAIT,
// protocol-error injection and reset clearing of err.
module tb_conv2_sched;
    import conv2_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, err;

    conv2_sched_if bus();

    conv2_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int exp_pos, exp_tap, mv_cnt, dly, stall_left, rise_cyc, done_cnt;
    bit mon_en, prev_fre, prev_clr, prev_done;
    bit stall_arm, stalling, chk_rise, abort_arm, aborted;
    bit busy_start_arm, inj_arm, err_chk, seen_done, start_req;

    int tbl_pos[5]  = '{0, 1, 29, 30, 1259};
    int tbl_addr[5] = '{0, 1, 29, 32, 1341};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    task model_reset();
        exp_pos = 0;
        exp_tap = 0;
        mv_cnt  = 0;
        dly     = 0;
    endtask

    // One clock: observe at negedge, drive this cycle's inputs, check against the model.
    task step();
        int  ea;
        bit  acc;
        @(negedge clk);
        cyc++;
        start = start_req;
        start_req = 1'b0;
        abort = 1'b0;
        bus.mac_done = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) bus.mac_done = 1'b1;
        end
        if (stall_arm && bus.out_valid && bus.out_pos == 7) begin
            stall_arm  = 1'b0;
            stall_left = 5;
            stalling   = 1'b1;
        end
        if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else begin
            bus.out_ready = 1'b1;
            if (stalling) begin
                stalling = 1'b0;
                rise_cyc = cyc;
                chk_rise = 1'b1;
            end
        end
        if (!mon_en) begin
            prev_fre  = 1'b0;
            prev_clr  = 1'b0;
            prev_done = 1'b0;
            return;
        end
        if (aborted) begin
            aborted = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_out_valid", bus.out_valid, 0);
            chk("abort_mac_valid", bus.mac_valid, 0);
            model_reset();
        end
        if (err_chk) begin
            err_chk = 1'b0;
            chk("err_set", err, 1);
        end
        if (prev_done) chk("busy_fall", busy, 0);
        if (prev_clr)  chk("clear_then_issue", bus.feat_rd_en, 1);
        if (bus.mac_valid || prev_fre) chk("mac_valid_align", bus.mac_valid, prev_fre);
        if (!bus.out_ready) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_pos", bus.out_pos, 7);
            chk("stall_no_fetch", bus.feat_rd_en, 0);
        end
        if (bus.feat_rd_en) begin
            if (chk_rise) begin
                chk_rise = 1'b0;
                chk("restart_latency", cyc - rise_cyc, 2);
            end
            ea = (exp_pos / OUT_W) * IN_W + (exp_pos % OUT_W) + exp_tap;
            chk("feat_addr", bus.feat_rd_addr, ea);
            chk("w_addr", bus.w_rd_addr, exp_tap);
            chk("w_rd_en", bus.w_rd_en, 1);
            for (int k = 0; k < 5; k++)
                if (exp_pos == tbl_pos[k]) chk("vec_addr", bus.feat_rd_addr, tbl_addr[k] + exp_tap);
            if (busy_start_arm && exp_pos == 50) begin
                busy_start_arm = 1'b0;
                start = 1'b1;
            end
            if (inj_arm && exp_pos == 2 && exp_tap == 1) begin
                inj_arm = 1'b0;
                bus.mac_done = 1'b1;
                err_chk = 1'b1;
            end
            exp_tap++;
        end
        if (bus.mac_valid) begin
            mv_cnt++;
            if (mv_cnt == 3) dly = 2;
        end
        if (abort_arm && exp_pos == 100 && dly == 1) begin
            abort_arm = 1'b0;
            abort     = 1'b1;
            dly       = 0;
            aborted   = 1'b1;
            chk("abort_in_wait_busy", busy, 1);
        end
        acc = bus.out_valid && bus.out_ready;
        if (acc) begin
            chk("out_pos", bus.out_pos, exp_pos);
            chk("mac_valid_count", mv_cnt, 3);
            chk("taps_issued", exp_tap, 3);
            exp_pos++;
            exp_tap = 0;
            mv_cnt  = 0;
        end
        if (done) begin
            done_cnt++;
            seen_done = 1'b1;
            chk("done_after_last", exp_pos, OUT_W * OUT_H);
        end
        prev_fre  = bus.feat_rd_en;
        prev_clr  = bus.mac_clear;
        prev_done = done;
    endtask

    initial begin
        bus.mac_done  = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        mon_en = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mac_valid", bus.mac_valid, 0);
        chk("rst_mac_clear", bus.mac_clear, 0);
        chk("rst_feat_rd_en", bus.feat_rd_en, 0);
        chk("rst_feat_addr", bus.feat_rd_addr, 0);
        chk("rst_out_pos", bus.out_pos, 0);

        // Full pass with a stall at position 7 and a stray start at position 50.
        stall_arm      = 1'b1;
        busy_start_arm = 1'b1;
        done_cnt       = 0;
        seen_done      = 1'b0;
        start_req      = 1'b1;
        for (int i = 0; i < 12000 && !seen_done; i++) step();
        chk("pass1_done_seen", seen_done, 1);
        repeat (20) step();
        chk("pass1_done_count", done_cnt, 1);
        chk("pass1_err", err, 0);
        chk("pass1_idle", busy, 0);
        chk("pass1_pos_cleared", bus.out_pos, 0);

        // Abort while waiting on position 100.
        model_reset();
        abort_arm = 1'b1;
        start_req = 1'b1;
        for (int i = 0; i < 2000 && abort_arm; i++) step();
        chk("abort_reached", abort_arm, 0);
        step();
        repeat (3) step();
        chk("abort_err", err, 0);
        chk("abort_pos_cleared", bus.out_pos, 0);

        // Restart from position 0 with a stray mac_done during ISSUE.
        inj_arm   = 1'b1;
        done_cnt  = 0;
        seen_done = 1'b0;
        start_req = 1'b1;
        for (int i = 0; i < 12000 && !seen_done; i++) step();
        chk("pass3_done_seen", seen_done, 1);
        repeat (3) step();
        chk("pass3_done_count", done_cnt, 1);
        chk("err_held", err, 1);

        mon_en = 1'b0;
        rst_n  = 1'b0;
        repeat (2) step();
        rst_n  = 1'b1;
        step();
        chk("err_cleared", err, 0);
        chk("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
